mdt_update_scheduler: RTL
=========================

// Module: mdt_update_scheduler
// PURPOSE
//  Owns the single write port of the memory dependency table (MDT). Buffers order-violation training
//  writes from up to REQ_NUM store pipes and drains one per cycle. Runs the post-reset init sweep and
//  periodic/forced clear sweeps so stale "conflict" bits age out. Sits between LSQ and MDT RAM.
// PARAMETERS
//  ENTRY_NUM       1024   MDT entries; power of two
//  INDEX_WIDTH     10     log2(ENTRY_NUM)
//  REQ_NUM         2      training request ports (store issue width)
//  QUEUE_DEPTH     4      training FIFO entries; power of two, >= REQ_NUM
//  CLEAR_INTERVAL  65536  RUN cycles between automatic clear sweeps; 0 disables automatic clear
// PORTS
//  clk        in   1                      clock
//  rst        in   1                      asynchronous, active-low reset
//  reqValid   in   REQ_NUM                violation detected on store pipe i
//  reqIndex   in   REQ_NUM*INDEX_WIDTH    MDT index of conflicting load, pipe i at [i*IW +: IW]
//  clearReq   in   1                      one-cycle pulse: force a clear sweep
//  mdtWE      out  1                      MDT write enable (registered)
//  mdtWA      out  INDEX_WIDTH            MDT write address (registered)
//  mdtWV      out  1                      MDT write data, counter bit (registered)
//  busy       out  1                      INIT or CLEAR sweep in progress; MDT reads invalid
//  dropCount  out  8                      saturating count of dropped training requests
// BEHAVIOUR
//  - Reset (rst=0): state=INIT, sweepIdx=0, FIFO empty, interval counter=0; mdtWE=0, mdtWA=0,
//    mdtWV=0, busy=1, dropCount=0. Reset mid-sweep or mid-RUN restarts INIT from index 0.
//  - States: INIT -> RUN when sweepIdx==ENTRY_NUM-1 written; RUN -> CLEAR on clearReq or interval
//    counter==CLEAR_INTERVAL-1 (CLEAR_INTERVAL!=0); CLEAR -> RUN when ENTRY_NUM-1 written.
//  - INIT/CLEAR: each cycle register mdtWE=1, mdtWA=sweepIdx, mdtWV=0; sweepIdx++. Sweep takes exactly
//    ENTRY_NUM cycles. busy=1 throughout, drops to 0 the cycle the last sweep write is on mdtWE.
//  - clearReq during INIT/CLEAR is ignored (no re-arm). Interval counter zeroed on entering RUN and
//    counts only in RUN.
//  - Enqueue (all states): valid requests processed in ascending pipe order. A request whose index
//    equals a lower-numbered valid request in the same cycle is coalesced (not enqueued, not dropped).
//    Each remaining request is enqueued if a slot is free after earlier pipes this cycle, else dropped
//    and dropCount += 1 (saturates at 255). Same-cycle dequeue does NOT free a slot for enqueue.
//  - Dequeue: only in RUN, when FIFO non-empty: pop head, register mdtWE=1, mdtWA=head, mdtWV=1.
//    Latency: request valid in cycle t is on mdtWE at t+1 earliest (FIFO empty, RUN).
//  - RUN with empty FIFO: mdtWE=0, mdtWA/mdtWV hold last value.
//  - FIFO contents survive a CLEAR sweep and drain afterwards (training newer than clear is kept).
//  - RUN->CLEAR transition cycle: a pending head is not popped; sweep write takes priority.
//  - Pointers: INDEX-free FIFO with wrap-around head/tail of log2(QUEUE_DEPTH) bits + count of
//    log2(QUEUE_DEPTH)+1 bits; full when count==QUEUE_DEPTH, empty when count==0.
// TESTING
//  1. Release reset, no requests -> mdtWE=1,mdtWV=0 for addresses 0..1023 on 1024 consecutive cycles,
//     busy falls with last write, then mdtWE=0.
//  2. RUN, reqValid=01, reqIndex[0]=0x15 at t -> mdtWE=1, mdtWA=0x15, mdtWV=1 at t+1 only.
//  3. RUN, both pipes valid, indices 0x3 and 0x3 -> single write of 0x3, dropCount unchanged.
//  4. During INIT, 3 cycles of 2 distinct requests (QUEUE_DEPTH=4) -> 4 queued, 2 dropped,
//     dropCount=2; after INIT 4 writes in enqueue order on consecutive cycles.
//  5. RUN, clearReq pulse with 1 queued entry -> 1024-cycle clear sweep, then queued entry written;
//     second clearReq mid-sweep ignored.
//  6. CLEAR_INTERVAL=16 override: after 16 idle RUN cycles CLEAR starts; rst=0 at sweepIdx=500 ->
//     outputs zero immediately, INIT restarts from 0 after release.

Source files
------------

// File: rtl/mdt_update_scheduler_if.sv
// rtl/mdt_update_scheduler_if.sv - training request and MDT write port bundle for mdt_update_scheduler
interface mdt_update_scheduler_if #(
  parameter int INDEX_WIDTH = 10,
  parameter int REQ_NUM     = 2
);
  logic [REQ_NUM-1:0]             reqValid;
  logic [REQ_NUM*INDEX_WIDTH-1:0] reqIndex;
  logic                           clearReq;
  logic                           mdtWE;
  logic [INDEX_WIDTH-1:0]         mdtWA;
  logic                           mdtWV;
  logic                           busy;
  logic [7:0]                     dropCount;

  modport master (
    output reqValid, reqIndex, clearReq,
    input  mdtWE, mdtWA, mdtWV, busy, dropCount
  );

  modport slave (
    input  reqValid, reqIndex, clearReq,
    output mdtWE, mdtWA, mdtWV, busy, dropCount
  );
endinterface

// File: rtl/mdt_update_scheduler.sv
// rtl/mdt_update_scheduler.sv - single MDT write port: training FIFO drain plus init/clear sweeps
// An empty FIFO in RUN forwards the first new request straight to the write port.
module mdt_update_scheduler #(
  parameter int ENTRY_NUM      = 1024,
  parameter int INDEX_WIDTH    = 10,
  parameter int REQ_NUM        = 2,
  parameter int QUEUE_DEPTH    = 4,
  parameter int CLEAR_INTERVAL = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  mdt_update_scheduler_if.slave bus
);

  localparam int PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int ICNT_W = (CLEAR_INTERVAL > 1) ? $clog2(CLEAR_INTERVAL) : 1;
  localparam logic [ICNT_W-1:0]      INTV_LAST  = ICNT_W'((CLEAR_INTERVAL > 0) ? CLEAR_INTERVAL - 1 : 0);
  localparam logic [INDEX_WIDTH-1:0] SWEEP_LAST = INDEX_WIDTH'(ENTRY_NUM - 1);
  localparam logic [CNT_W-1:0]       DEPTH_C    = CNT_W'(QUEUE_DEPTH);
  localparam bit                     AUTO_CLR   = (CLEAR_INTERVAL != 0);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_CLEAR} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_idx_q, sweep_idx_d;
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [INDEX_WIDTH-1:0] mem_q [QUEUE_DEPTH];
  logic [INDEX_WIDTH-1:0] mem_d [QUEUE_DEPTH];
  logic [ICNT_W-1:0]      intv_q, intv_d;
  logic                   mdt_we_q, mdt_we_d;
  logic [INDEX_WIDTH-1:0] mdt_wa_q, mdt_wa_d;
  logic                   mdt_wv_q, mdt_wv_d;
  logic                   busy_q, busy_d;
  logic [7:0]             drop_q, drop_d;

  logic [INDEX_WIDTH-1:0] req_idx [REQ_NUM];
  logic [CNT_W-1:0]       n_enq;
  logic [INDEX_WIDTH-1:0] first_new;
  logic                   dup;
  logic                   trig;
  logic                   pop;

  always_comb begin
    for (int i = 0; i < REQ_NUM; i++) begin
      req_idx[i] = bus.reqIndex[i*INDEX_WIDTH +: INDEX_WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    intv_d      = intv_q;
    mdt_we_d    = mdt_we_q;
    mdt_wa_d    = mdt_wa_q;
    mdt_wv_d    = mdt_wv_q;
    busy_d      = busy_q;
    drop_d      = drop_q;
    mem_d       = mem_q;
    n_enq       = '0;
    first_new   = '0;
    dup         = 1'b0;
    pop         = 1'b0;

    // Slot availability is judged against the registered count only.
    for (int i = 0; i < REQ_NUM; i++) begin
      dup = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (bus.reqValid[j] && (req_idx[j] == req_idx[i])) dup = 1'b1;
      end
      if (bus.reqValid[i] && !dup) begin
        if ((count_q + n_enq) < DEPTH_C) begin
          mem_d[tail_q + n_enq[PTR_W-1:0]] = req_idx[i];
          if (n_enq == '0) first_new = req_idx[i];
          n_enq = n_enq + CNT_W'(1);
        end else if (drop_d != 8'hFF) begin
          drop_d = drop_d + 8'd1;
        end
      end
    end

    trig = (state_q == S_RUN) && (bus.clearReq || (AUTO_CLR && (intv_q == INTV_LAST)));

    if ((state_q != S_RUN) || trig) begin
      mdt_we_d = 1'b1;
      mdt_wa_d = sweep_idx_q;
      mdt_wv_d = 1'b0;
      if (sweep_idx_q == SWEEP_LAST) begin
        state_d     = S_RUN;
        sweep_idx_d = '0;
        busy_d      = 1'b0;
        intv_d      = '0;
      end else begin
        sweep_idx_d = sweep_idx_q + INDEX_WIDTH'(1);
        busy_d      = 1'b1;
        if (trig) state_d = S_CLEAR;
      end
    end else begin
      intv_d = intv_q + ICNT_W'(1);
      if ((count_q != '0) || (n_enq != '0)) begin
        pop      = 1'b1;
        mdt_we_d = 1'b1;
        mdt_wa_d = (count_q != '0) ? mem_q[head_q] : first_new;
        mdt_wv_d = 1'b1;
      end else begin
        mdt_we_d = 1'b0;
      end
    end

    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + n_enq[PTR_W-1:0];
    count_d = count_q + n_enq - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT;
      sweep_idx_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      intv_q      <= '0;
      mdt_we_q    <= 1'b0;
      mdt_wa_q    <= '0;
      mdt_wv_q    <= 1'b0;
      busy_q      <= 1'b1;
      drop_q      <= '0;
      for (int k = 0; k < QUEUE_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      intv_q      <= intv_d;
      mdt_we_q    <= mdt_we_d;
      mdt_wa_q    <= mdt_wa_d;
      mdt_wv_q    <= mdt_wv_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.mdtWE     = mdt_we_q;
  assign bus.mdtWA     = mdt_wa_q;
  assign bus.mdtWV     = mdt_wv_q;
  assign bus.busy      = busy_q;
  assign bus.dropCount = drop_q;

endmodule
